// File: rtl/mux8x1_rr_collector.sv
// -----------------------------------------------------------------------------
// mux8x1_rr_collector
//
// Collects eight independent valid/ready input channels into one registered
// output stream. A round-robin arbiter picks the source. Each output beat
// carries the 3-bit index of its source channel on out_sel, so a downstream
// 1x8 demux can split the stream again using out_sel as its select.
//
// Handshake rules (both sides):
//   A beat moves when valid && ready are both high at a rising clock edge.
//   The producer holds its data stable while valid is high and ready is low.
//   On the output side, out_valid never drops without a transfer.
//   On the input side, a channel may lower in_valid without transferring.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   E          enable; when low, no new channel is granted
//   in_data    packed channel data; channel k is in_data[k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready; combinational, at most one bit set
//   out_data   registered data of the selected beat
//   out_sel    registered index of the beat's source channel
//   out_valid  registered output valid
//   out_ready  downstream ready
// -----------------------------------------------------------------------------
module mux8x1_rr_collector #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               E,
    input  logic [8*WIDTH-1:0] in_data,
    input  logic [7:0]         in_valid,
    output logic [7:0]         in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    // Index of the most recently granted channel. Its reset value is 7, so
    // the search after reset starts at channel 0.
    logic [2:0]       last_grant;

    logic             slot_free;
    logic             grant_found;
    logic [2:0]       grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             in_xfer;
    logic             out_xfer;

    // The output register can take a new beat when it is empty, or when
    // its current beat leaves in this same cycle. This gives one beat per
    // clock.
    assign slot_free = !out_valid || out_ready;
    assign out_xfer  = out_valid && out_ready;

    // Round-robin search. It starts at last_grant+1 and wraps through all
    // eight channels. When i reaches 8, the 3-bit offset wraps to 0, so
    // last_grant itself is checked last. A channel that is the only one
    // valid is therefore granted every time.
    always_comb begin
        logic [2:0] cand;
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        cand        = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            cand = last_grant + 3'(i);
            if (!grant_found && in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // in_ready is gated by rst_n so that no channel sees a ready while
    // reset is asserted.
    always_comb begin
        in_ready = 8'b0;
        if (rst_n && E && slot_free && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign in_xfer    = |(in_valid & in_ready);
    assign grant_data = in_data[32'(grant_idx)*WIDTH +: WIDTH];

    // When there is no transfer, out_data and out_sel keep their values.
    // This keeps a stalled beat stable. After a drain with no refill, it
    // leaves harmless stale values behind an out_valid of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= 3'd0;
            last_grant <= 3'd7;
        end else begin
            if (in_xfer) begin
                out_data   <= grant_data;
                out_sel    <= grant_idx;
                out_valid  <= 1'b1;
                last_grant <= grant_idx;
            end else if (out_xfer) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux8x1_rr_collector.sv
module tb_mux8x1_rr_collector;

    localparam int WIDTH = 3;

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               rst_n;
    logic               E;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_valid;
    logic [7:0]         in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_valid;
    logic               out_ready;

    always #5 clk = ~clk;

    mux8x1_rr_collector #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .E         (E),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- scoreboard ----------------
    // Each entry holds the expected output beat as {sel[2:0], data[WIDTH-1:0]}.
    logic [3+WIDTH-1:0] exp_q[$];
    int                 last_m;      // model of the last granted channel
    int                 n_checks = 0;
    int                 n_errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [7:0] v, input int last);
        for (int n = 1; n <= 8; n++) begin
            int c;
            c = (last + n) % 8;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic e, input logic [7:0] v, input logic r, input logic ramp);
        E         = e;
        in_valid  = v;
        out_ready = r;
        for (int k = 0; k < 8; k++)
            in_data[k*WIDTH +: WIDTH] = ramp ? WIDTH'(k) : WIDTH'($urandom_range(0, 7));
    endtask

    // Checks the current cycle at the falling edge and updates the model.
    // Then it advances to just after the next rising edge, where the
    // caller drives the next inputs.
    task automatic cycle();
        int             g;
        logic [7:0]     exp_rdy;
        logic           slot;
        @(negedge clk);
        check("out_valid", 16'(out_valid), 16'(exp_q.size() != 0));
        slot    = (exp_q.size() == 0) || out_ready;
        g       = (rst_n && E && slot) ? model_grant(in_valid, last_m) : -1;
        exp_rdy = (g >= 0) ? (8'd1 << g) : 8'd0;
        check("in_ready", 16'(in_ready), 16'(exp_rdy));
        if (exp_q.size() != 0) begin
            check("out_beat", 16'({out_sel, out_data}), 16'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
        end
        if (g >= 0) begin
            exp_q.push_back({3'(g), in_data[g*WIDTH +: WIDTH]});
            last_m = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic reset_checks();
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_sel",   16'(out_sel),   16'd0);
        check("rst_out_data",  16'(out_data),  16'd0);
        check("rst_in_ready",  16'(in_ready),  16'd0);
        exp_q.delete();
        last_m = 7;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        drive(1'b1, 8'hFF, 1'b1, 1'b1);
        last_m = 7;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        rst_n = 1'b1;

        // Round-robin with all channels valid: sel/data 0..7,0..7.
        drive(1'b1, 8'hFF, 1'b1, 1'b1);
        run(17);

        // Backpressure: load channel 3, stall for 4 cycles, then release.
        drive(1'b1, 8'b0000_1000, 1'b1, 1'b0);
        run(1);
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        run(4);
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        run(2);

        // Sparse with wrap: make channel 6 the last grant, then 0 then 5.
        drive(1'b1, 8'b0100_0000, 1'b1, 1'b0);
        run(1);
        drive(1'b1, 8'b0010_0001, 1'b1, 1'b0);
        run(3);

        // Enable gating: the held beat drains, then nothing is granted.
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        run(1);
        drive(1'b0, 8'hFF, 1'b1, 1'b0);
        run(4);
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        run(4);

        // Single channel: channel 2 is granted every cycle.
        drive(1'b1, 8'b0000_0100, 1'b1, 1'b0);
        run(6);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 9) != 0), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 3) != 0), 1'b0);
            run(1);
        end

        // Reset in mid-operation while a beat is held.
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        run(2);
        #2 rst_n = 1'b0;
        #1 reset_checks();
        run(1);
        rst_n = 1'b1;
        drive(1'b1, 8'hFF, 1'b1, 1'b1);
        run(1);
        check("post_rst_first_sel", 16'(exp_q.size() != 0 ? exp_q[0][3+WIDTH-1:WIDTH] : 3'd7), 16'd0);
        run(4);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        run(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux8x1_rr_collector.md
Name: mux8x1_rr_collector

Overview:
- 8-input to 1-output stream multiplexer with a round-robin arbiter; the merge-side counterpart of the 1x8 select demultiplexer.
- Eight independent valid/ready channels are collected into one registered output stream.
- Each output beat carries the 3-bit index of its source channel (out_sel), so a downstream demux can re-split the stream using out_sel as S.

Parameters:
- WIDTH, 3, data width per channel in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- E  input  1  enable; when 0, no new channel is granted.
- in_data  input  8*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  8  per-channel valid.
- in_ready  output  8  per-channel ready; combinational; at most one bit set.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  3  registered index of the source channel for out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_sel=0, last_grant=7, so channel 0 has first priority. in_ready=0 while reset is asserted.
- Output register state: one output register with one entry.
  - slot_free = !out_valid || out_ready.
  - A transfer on the output happens when out_valid && out_ready.
- Grant, combinational:
  - When E=1, slot_free=1 and in_valid!=0, grant the first channel with valid set, searching from (last_grant+1) mod 8 upward with wrap.
  - in_ready = one-hot of the granted channel. Otherwise in_ready=0.
- Input handshake: channel k transfers when in_valid[k] && in_ready[k].
- On a transfer from channel k, at the next edge:
  - out_data <= in_data[k]
  - out_sel <= k
  - out_valid <= 1
  - last_grant <= k
- If there is an output transfer and no input transfer in the same cycle, out_valid <= 0. out_data and out_sel hold their values.
- Simultaneous drain and refill (out_valid=1, out_ready=1, a channel granted): the new beat is loaded in the same cycle. This gives full throughput of one beat per clock.
- Stall: out_valid=1 and out_ready=0 -> in_ready=0. out_data and out_sel are held stable until the beat is accepted.
- Latency: an input accepted at edge t appears on the output after edge t (1 cycle).
- Fairness:
  - With all 8 channels valid continuously and out_ready=1, the grant order is 0,1,...,7,0,...
  - No channel waits more than 7 grants once its valid is asserted.
- last_grant updates only on an actual input transfer. A refused or idle cycle does not rotate priority.
- E=0: no new grants. A beat already held in the output register still drains normally. Priority state is preserved across E toggles.
- A valid that drops without a transfer is legal on the input side and carries no penalty. The output side never drops out_valid without a transfer.
- Reset mid-operation: the held beat is discarded, out_valid=0 immediately, priority returns to channel 0.
- Single-channel case: only channel k valid -> it is granted every cycle the slot is free, regardless of last_grant.

Test Plan:
- Reset: assert rst_n=0 mid-beat with out_valid=1 -> out_valid=0, out_sel=0, out_data=0 asynchronously. After release with in_valid=8'hFF, first grant is channel 0.
- Round-robin: in_valid=8'hFF, in_data channel k = k (WIDTH=3), out_ready=1, E=1 for 16 cycles -> out_sel and out_data sequence 0..7,0..7; out_valid continuously 1 after the first cycle.
- Backpressure: out_ready=0 for 4 cycles with a beat from channel 3 held -> in_ready=0, out_sel=3 and out_data stable. Then out_ready=1 -> next grant is channel 4 in the same cycle.
- Sparse and wrap: last_grant=6, in_valid=8'b0010_0001 -> grant channel 0 (wrap past 7), then channel 5.
- Enable gating: E=0 with in_valid=8'hFF and a beat held -> the held beat drains, then out_valid=0 and in_ready=0. E=1 -> grants resume at last_grant+1.
- Single channel: only in_valid[2]=1, out_ready=1 -> in_ready=8'b0000_0100 every cycle, 1 beat/clock, out_sel=2.
